// File: rtl/fifo_rd_pkg.sv
// Shared types and sizes for the FIFO burst read controller.
package fifo_rd_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned OBUF_DEPTH = 2;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned REM_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_burst_obuf.sv
// Two-entry in-order output buffer; head entry drives the downstream port.
module fifo_burst_obuf
  import fifo_rd_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head,
  output logic              valid
);

  logic [DATA_W-1:0] tail;
  logic              do_pop;
  logic              do_push;

  assign do_pop  = pop & valid;
  assign do_push = push & ((occ != OCC_W'(OBUF_DEPTH)) | do_pop);

  // Head only moves on a pop, so it stays stable while downstream stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      occ   <= '0;
      head  <= '0;
      tail  <= '0;
      valid <= 1'b0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == '0) head <= push_data;
          else           tail <= push_data;
          occ   <= occ + OCC_W'(1);
          valid <= 1'b1;
        end
        2'b01: begin
          if (occ == OCC_W'(2)) head <= tail;
          occ   <= occ - OCC_W'(1);
          valid <= (occ != OCC_W'(1));
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains BURST words from a registered-read FIFO and streams them out
// on a valid/ready handshake without ever dropping a returned word.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              FIFO_EMPTY,
  input  logic [DATA_W-1:0] FIFO_DOUT,
  input  logic              FIFO_VALID,
  input  logic              FIFO_UNDER,
  output logic              FIFO_RD,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  rd_state_t        state;
  logic [REM_W-1:0] remaining;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] pending;
  logic             pop;
  logic             room;

  assign pop     = OUT_VALID & OUT_READY;
  assign pending = occ + OCC_W'(inflight);
  // A read may only be issued if its word is guaranteed a buffer slot.
  assign room    = (pending < OCC_W'(OBUF_DEPTH)) |
                   ((pending == OCC_W'(OBUF_DEPTH)) & pop);
  assign FIFO_RD = ~RST & (state == READ) & (remaining != '0) & ~FIFO_EMPTY & room;

  fifo_burst_obuf u_obuf (
    .CLK       (CLK),
    .RST       (RST),
    .push      (FIFO_VALID),
    .push_data (FIFO_DOUT),
    .pop       (pop),
    .occ       (occ),
    .head      (OUT_DATA),
    .valid     (OUT_VALID)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      inflight <= FIFO_RD | (inflight & ~FIFO_VALID);

      if (FIFO_UNDER | (FIFO_VALID & ~inflight)) ERR <= 1'b1;
      else if ((state == IDLE) & START)          ERR <= 1'b0;

      case (state)
        IDLE: begin
          if (START) begin
            remaining <= REM_W'(BURST);
            state     <= READ;
            BUSY      <= 1'b1;
          end
        end
        READ: begin
          if (FIFO_RD) begin
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Last word is the only one left and is leaving this cycle.
          if ((occ == OCC_W'(1)) & ~inflight & pop) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
